// File: rtl/alu_issue_stage.sv
// Operand issue stage: decodes an 8-bit logic-unit instruction, reads a 4-entry
// register file with writeback bypass, and stalls on pending-register hazards.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

module alu_issue_stage #(
  parameter int unsigned WIDTH = `REG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_instr,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] first_op,
  output logic [WIDTH-1:0] second_op,
  output logic [1:0]       log_func,
  output logic [1:0]       out_rd,
  input  logic             wb_en,
  input  logic [1:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data
);

  localparam int unsigned NREG = 4;
  localparam int unsigned AW   = 2;

  logic [1:0]       func;
  logic [AW-1:0]    rd;
  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  wb_clear;
  logic [NREG-1:0]  pend_eff;
  logic [NREG-1:0]  set_mask;
  logic             hazard;
  logic             accept;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;

  assign {func, rd, rs1, rs2} = in_instr;

  // Pending bits as seen this cycle, after a same-cycle writeback has released one.
  always_comb begin
    wb_clear = '0;
    if (wb_en) wb_clear[wb_addr] = 1'b1;
  end

  assign pend_eff = pending & ~wb_clear;
  assign hazard   = pend_eff[rs1] | pend_eff[rs2] | pend_eff[rd];
  assign in_ready = rst_n & (~out_valid | out_ready) & ~hazard;
  assign accept   = in_valid & in_ready;

  always_comb begin
    set_mask = '0;
    if (accept) set_mask[rd] = 1'b1;
  end

  // Writeback data arriving this cycle bypasses the register file.
  assign rs1_val = (wb_en && (wb_addr == rs1)) ? wb_data : regs[rs1];
  assign rs2_val = (wb_en && (wb_addr == rs2)) ? wb_data : regs[rs2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // An accept setting pending[rd] wins over a same-cycle writeback clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pend_eff | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      first_op  <= '0;
      second_op <= '0;
      log_func  <= 2'b00;
      out_rd    <= 2'b00;
    end else if (accept) begin
      out_valid <= 1'b1;
      first_op  <= rs1_val;
      second_op <= rs2_val;
      log_func  <= func;
      out_rd    <= rd;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios followed by random traffic,
// all compared against a register-file/scoreboard model kept in the bench.
module tb_alu_issue_stage;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [7:0]   in_instr;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] first_op;
  logic [W-1:0] second_op;
  logic [1:0]   log_func;
  logic [1:0]   out_rd;
  logic         wb_en;
  logic [1:0]   wb_addr;
  logic [W-1:0] wb_data;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [W-1:0] m_regs [4];
  logic [3:0]   m_pend;
  logic         e_valid;
  logic [W-1:0] e_first;
  logic [W-1:0] e_second;
  logic [1:0]   e_func;
  logic [1:0]   e_rd;

  alu_issue_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .first_op(first_op), .second_op(second_op),
    .log_func(log_func), .out_rd(out_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_pend   = 4'b0000;
    e_valid  = 1'b0;
    e_first  = '0;
    e_second = '0;
    e_func   = 2'b00;
    e_rd     = 2'b00;
  endtask

  task automatic check_slot();
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("first_op",  32'(first_op),  32'(e_first));
    chk("second_op", 32'(second_op), 32'(e_second));
    chk("log_func",  32'(log_func),  32'(e_func));
    chk("out_rd",    32'(out_rd),    32'(e_rd));
    chk("pending",   32'(dut.pending), 32'(m_pend));
  endtask

  // One clock cycle: drive, check in_ready, clock, update model, check slot.
  task automatic cycle(input logic iv, input logic [7:0] ins, input logic ordy,
                       input logic we, input logic [1:0] wa, input logic [W-1:0] wd);
    logic [1:0] f, rd, r1, r2;
    logic [3:0] busy;
    logic       rdy, acc;
    in_valid  = iv;
    in_instr  = ins;
    out_ready = ordy;
    wb_en     = we;
    wb_addr   = wa;
    wb_data   = wd;
    #1;
    {f, rd, r1, r2} = ins;
    busy = m_pend;
    if (we) busy[wa] = 1'b0;
    rdy = (!e_valid || ordy) && !(busy[r1] || busy[r2] || busy[rd]);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    acc = iv && rdy;
    @(posedge clk);
    if (acc) begin
      e_first  = (we && wa == r1) ? wd : m_regs[r1];
      e_second = (we && wa == r2) ? wd : m_regs[r2];
      e_func   = f;
      e_rd     = rd;
      e_valid  = 1'b1;
    end else if (e_valid && ordy) begin
      e_valid = 1'b0;
    end
    if (we) begin
      m_regs[wa] = wd;
      m_pend[wa] = 1'b0;
    end
    if (acc) m_pend[rd] = 1'b1;
    #1;
    check_slot();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    model_reset();
    #2;
    check_slot();
    chk("in_ready_in_reset", 32'(in_ready), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Register initialisation through writeback
    cycle(0, 8'h00, 1, 1, 2'd0, 8'h0F);
    cycle(0, 8'h00, 1, 1, 2'd1, 8'hF0);
    cycle(0, 8'h00, 1, 1, 2'd2, 8'h55);
    cycle(0, 8'h00, 1, 1, 2'd3, 8'hAA);

    // AND r0 = r0 & r1
    cycle(1, 8'b00_00_00_01, 1, 0, 2'd0, 8'h00);
    chk("and_first",  32'(first_op),  32'(8'h0F));
    chk("and_second", 32'(second_op), 32'(8'hF0));
    chk("and_pend",   32'(dut.pending), 32'(4'b0001));

    // OR r1 = r0 | r2 stalls on pending r0, released by writeback with bypass
    for (int i = 0; i < 3; i++) begin
      cycle(1, 8'b01_01_00_10, 1, 0, 2'd0, 8'h00);
      chk("stall_ready", 32'(in_ready), 32'(0));
    end
    cycle(1, 8'b01_01_00_10, 1, 1, 2'd0, 8'h3C);
    chk("release_first",  32'(first_op),  32'(8'h3C));
    chk("release_second", 32'(second_op), 32'(8'h55));

    // Backpressure: slot held for 4 cycles, then accepted on out_ready
    for (int i = 0; i < 4; i++) cycle(1, 8'b00_10_10_11, 0, 0, 2'd0, 8'h00);
    cycle(1, 8'b00_10_10_11, 1, 0, 2'd0, 8'h00);
    chk("bp_accept_rd", 32'(out_rd), 32'(2));

    // Accept rd=2 while writeback targets r2: set wins, data written
    cycle(1, 8'b11_10_00_00, 1, 1, 2'd2, 8'h77);
    chk("simul_pend2", 32'(dut.pending[2]), 32'(1));
    chk("simul_reg2",  32'(dut.regs[2]), 32'(8'h77));

    // Clear remaining pending bits, then four independent back-to-back issues
    cycle(0, 8'h00, 1, 1, 2'd1, 8'h11);
    cycle(0, 8'h00, 1, 1, 2'd2, 8'h22);
    cycle(0, 8'h00, 1, 1, 2'd0, 8'h33);
    cycle(1, 8'b00_00_01_10, 1, 0, 2'd0, 8'h00);
    cycle(1, 8'b01_01_10_11, 1, 0, 2'd0, 8'h00);
    cycle(1, 8'b10_10_11_11, 1, 0, 2'd0, 8'h00);
    cycle(1, 8'b11_11_11_11, 1, 0, 2'd0, 8'h00);
    chk("b2b_pend", 32'(dut.pending), 32'(4'b1111));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom));
    end

    // Reset mid-operation with out_valid=1 and pending=1010
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
    cycle(1, 8'b00_01_00_00, 1, 0, 2'd0, 8'h00);
    cycle(1, 8'b01_11_00_00, 1, 0, 2'd0, 8'h00);
    chk("pre_reset_pend",  32'(dut.pending), 32'(4'b1010));
    chk("pre_reset_valid", 32'(out_valid),   32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_slot();
    chk("mid_reset_ready", 32'(in_ready), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
